serial_sub_ctrl: RTL and testbench
==================================

# serial_sub_ctrl

Bit-serial subtraction controller that sequences a single one-bit full-subtractor stage (difference = a ^ b ^ borrow, borrow-out = (~a & b) | (~(a ^ b) & borrow)) over WIDTH-bit operands, one bit per clock, LSB first. It accepts operands through a start/busy/done handshake, holds the running borrow between bit steps, and publishes a registered WIDTH-bit difference and final borrow. It sits between a requesting master and the subtractor datapath, trading latency for area.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 1..32.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while busy = 0.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle completion pulse.
- diff  output  WIDTH  registered result (a - b - bin) mod 2^WIDTH.
- bout  output  1  registered final borrow-out.
- zero  output  1  present only with SERIAL_SUB_FLAGS_EN; diff == 0.

## Operation
- States: IDLE, RUN, DONE; reset state IDLE.
- IDLE: start = 1 → load shift registers A ← a, B ← b, borrow ← bin, bit counter ← 0; go RUN.
- RUN, each cycle: compute df/br from A[0], B[0], borrow; shift df into MSB of internal result register; shift A, B right by one; borrow ← br; counter + 1. When counter reaches WIDTH-1 on this edge, go DONE.
- DONE, one cycle: diff ← internal result, bout ← borrow (loaded on entry edge); done = 1. Next edge: start = 1 → behave as IDLE accept (go RUN); otherwise go IDLE.
- start while busy = 1: ignored; no queuing, inputs not captured.
- diff/bout change only on the edge entering DONE; they hold the previous result throughout a subsequent run.
- Counter width: clog2(WIDTH+1); no wrap; WIDTH = 1 runs a single RUN cycle.
- a, b, bin may change freely after the accepting edge.

## Timing
- Reset (async assert, any state): state IDLE, busy = 0, done = 0, diff = 0, bout = 0, zero = 1 (if built); internal registers cleared. Run in progress is aborted, no done pulse.
- Reset deassertion: first accepting edge is the first rising clk edge with rst low.
- Accept on edge E0 → busy = 1 after E0; RUN for edges E1..E(WIDTH); state DONE and done = 1, busy = 0 after E(WIDTH); done drops after E(WIDTH+1).
- Latency start-accept to done: WIDTH cycles. Throughput: one operation per WIDTH+1 cycles when start held high or reissued in the DONE cycle.
- busy and done are never high together.

## Configuration
- SERIAL_SUB_FLAGS_EN defined: zero port and a registered zero flag exist; zero updates on the same edge as diff (diff-next == 0), reset value 1.
- Undefined: no zero port, no flag logic; all other behaviour identical.

## Test plan
- WIDTH = 8, a = 8'h5A, b = 8'h3C, bin = 0 → after 8 cycles done pulse, diff = 8'h1E, bout = 0, zero = 0.
- a = 8'h00, b = 8'h01, bin = 0 → diff = 8'hFF, bout = 1; a = 8'h10, b = 8'h10, bin = 1 → diff = 8'hFF, bout = 1.
- a = 8'h10, b = 8'h10, bin = 0 (flags built) → diff = 8'h00, bout = 0, zero = 1; diff held at 8'h00 during next run.
- start pulsed with new operands mid-run (cycle 3) → ignored; result of original operands, single done pulse after cycle 8.
- start held high continuously, operands changed each accept → done every 9 cycles, each diff matches operands captured at its accept edge.
- rst asserted mid-run (cycle 4) → busy, done, diff, bout = 0 immediately; no done pulse; next start after release completes normally.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a-b-bin over WIDTH bits, LSB first; done pulses WIDTH cycles after accept, start ignored while busy.
// Optional registered zero flag and port when SERIAL_SUB_FLAGS_EN is defined.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic             brw_q, brw_d, bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             df, br, accept, last;

  assign df     = a_q[0] ^ b_q[0] ^ brw_q;
  assign br     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
  assign accept = (state_q != RUN) && start;
  assign last   = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    if (state_q == RUN) begin
      // Each difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      res_d = (res_q >> 1) | (WIDTH'(df) << (WIDTH - 1));
      brw_d = br;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        state_d = DONE;
        diff_d  = res_d;
        bout_d  = br;
      end
    end else if (accept) begin
      state_d = RUN;
      a_d     = a;
      b_d     = b;
      brw_d   = bin;
      cnt_d   = '0;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

`ifdef SERIAL_SUB_FLAGS_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if (state_q == RUN && last) zero_d = (res_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_q <= 1'b1;
    else     zero_q <= zero_d;
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomized and directed bench for serial_sub_ctrl against an arithmetic reference model.
module tb_serial_sub_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_FLAGS_EN
  logic         zero;
`endif

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .zero (zero)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: cycles of work left, done flag, published and pending result.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_diff = '0;
  logic         m_bout = 1'b0;
  logic [W-1:0] p_diff = '0;
  logic         p_bout = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0;
    m_done = 1'b0;
    m_diff = '0;
    m_bout = 1'b0;
  endtask

  task automatic model_edge();
    int d;
    if (rst) begin
      model_reset();
    end else if (m_left > 0) begin
      m_left--;
      m_done = (m_left == 0);
      if (m_left == 0) begin
        m_diff = p_diff;
        m_bout = p_bout;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_left = W;
        d      = int'(a) - int'(b) - int'(bin);
        p_diff = W'(d);
        p_bout = (d < 0);
      end
    end
  endtask

  task automatic check_outputs();
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("diff", 32'(diff), 32'(m_diff));
    chk("bout", 32'(bout), 32'(m_bout));
    chk("busy_done_excl", 32'(busy & done), 32'd0);
`ifdef SERIAL_SUB_FLAGS_EN
    chk("zero", 32'(zero), 32'(m_diff == '0));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ibin, input logic [W-1:0] ed, input logic eb);
    int cyc;
    a = ia; b = ib; bin = ibin; start = 1'b1;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    cyc = 0;
    while (!done && cyc < W + 4) begin
      step();
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(W));
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_FLAGS_EN
    chk({tag, "_zero"}, 32'(zero), 32'(ed == '0));
`endif
  endtask

  initial begin
    int ndone, last_step;
    logic [W-1:0] got;

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_FLAGS_EN
    chk("rst_zero", 32'(zero), 32'd1);
`endif
    step();
    step();
    rst = 1'b0;

    run_op("t5a3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    run_op("t0001", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run_op("t1010b", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
    run_op("t1010", 8'h10, 8'h10, 1'b0, 8'h00, 1'b0);

    // Result of zero must hold while a new run is in flight.
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("hold_diff", 32'(diff), 32'h00);
    chk("hold_busy", 32'(busy), 32'd1);
    while (busy) step();
    chk("hold_new", 32'(diff), 32'h22);
    step();

    // Mid-run start with new operands is ignored.
    a = 8'hA5; b = 8'h5A; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    got = '0;
    for (int k = 1; k <= W + 2; k++) begin
      start = (k == 3);
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      step();
      if (done) begin
        ndone++;
        got = diff;
      end
    end
    start = 1'b0;
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_diff", 32'(got), 32'h4B);

    // Back-to-back operations with start held high.
    ndone = 0;
    last_step = 0;
    start = 1'b1;
    for (int k = 1; k <= 5 * (W + 1); k++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      step();
      if (done) begin
        chk("b2b_period", 32'(k - last_step), 32'(W + 1));
        last_step = k;
        ndone++;
      end
    end
    start = 1'b0;
    chk("b2b_ndone", 32'(ndone), 32'd5);
    step();
    step();

    // Reset asserted mid-run aborts immediately.
    a = 8'h77; b = 8'h12; bin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_diff", 32'(diff), 32'd0);
    chk("arst_bout", 32'(bout), 32'd0);
    step();
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < W + 2; k++) begin
      step();
      if (done) ndone++;
    end
    chk("arst_nodone", 32'(ndone), 32'd0);
    run_op("post_rst", 8'h77, 8'h12, 1'b1, 8'h64, 1'b0);

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      start = ($urandom_range(0, 2) == 0);
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    start = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
